slab_compare_sched: RTL and testbench
=====================================

# slab_compare_sched

Sequencer that evaluates a complete ray/AABB slab test using a single shared floating-point greater-than comparator. The block accepts three entry distances and three exit distances per ray, in FloPoCo format. It reduces them to tnear = max(tmin) and tfar = min(tmax), then issues the final tnear-versus-tfar comparison. The block sits between the per-axis slab distance stage and the hit-result collector, and owns the comparator's operand ports.

## Interface
Parameters:
- WIDTH, 14, operand MSB index; every FP bus is [WIDTH:0], with exception bits [WIDTH:WIDTH-1], sign [WIDTH-2], then exponent and fraction.
- CMP_LAT, 3, cycles from operands appearing on cmp_a/cmp_b to the matching cmp_gt being valid; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input bundle valid
- in_ready  out  1  block can accept a bundle (IDLE only)
- tmin_x, tmin_y, tmin_z  in  WIDTH+1  entry distances
- tmax_x, tmax_y, tmax_z  in  WIDTH+1  exit distances
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts the result
- hit  out  1  1 = ray intersects the box (tnear not greater than tfar)
- tnear_out, tfar_out  out  WIDTH+1  reduced distances
- busy  out  1  state ≠ IDLE
- cmp_a, cmp_b  out  WIDTH+1  comparator operands
- cmp_gt  in  1  comparator result; 1 iff cmp_a−cmp_b is a normal, positive number

## Operation
- States: IDLE, STEP, DONE.
- Registers: six latched operands, tnear, tfar, step[2:0], and a wait counter wide enough for 0..CMP_LAT.

IDLE:
- in_ready=1, cmp_a=cmp_b=0.
- When in_valid&in_ready:
  - latch all six inputs;
  - tnear←tmin_x, tfar←tmax_x;
  - step←0, cnt←0;
  - go to STEP.

STEP:
- cmp_a/cmp_b are decoded combinationally from step, tnear and tfar, and stay stable for the whole step.
- cnt increments each cycle.
- When cnt==CMP_LAT, sample cmp_gt, apply the update below, clear cnt and advance step.

Step sequence:
- step0: a=tmin_y, b=tnear; if gt, tnear←tmin_y.
- step1: a=tmin_z, b=tnear; if gt, tnear←tmin_z.
- step2: a=tfar, b=tmax_y; if gt, tfar←tmax_y.
- step3: a=tfar, b=tmax_z; if gt, tfar←tmax_z.
- step4: a=tnear, b=tfar; hit←~gt; go to DONE.

Comparison semantics:
- Equal operands give gt=0, so the current value is kept and ties resolve to the earlier axis.
- A tnear==tfar final compare yields hit=1.
- Exception results (zero, inf, NaN difference) give gt=0; no special handling.

DONE:
- out_valid=1; hit, tnear_out and tfar_out are held stable.
- When out_ready, go to IDLE.
- in_valid is ignored while the block is not in IDLE.

Reset and abort:
- rst at any time forces IDLE immediately and discards the in-flight ray.
- Stale comparator pipeline contents are harmless, because cmp_gt is only sampled at cnt==CMP_LAT of a step issued after reset.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, hit=0;
  - tnear_out=tfar_out=0, cmp_a=cmp_b=0;
  - state=IDLE, step=0, cnt=0.
- Cycle 0 is the accept cycle. Step k occupies cycles 1+k(CMP_LAT+1) through (k+1)(CMP_LAT+1).
- out_valid rises in cycle 5(CMP_LAT+1)+1, which is cycle 21 for CMP_LAT=3.
- Throughput: at most one ray per 5(CMP_LAT+1)+2 cycles when out_ready is tied to 1.
  - The cycle after the DONE handshake is IDLE with in_ready=1.
  - Acceptance is not combined with the DONE handshake.
- Outputs stay frozen through any number of out_ready=0 cycles.
- All outputs are combinational from registered state only; there is no combinational in→out path.

## Test plan
Bench instantiates the team comparator with CMP_LAT matched, values as normal FloPoCo encodings.
- Ray 1:
  - stimulus: tmin=(1.0, 2.0, 0.5), tmax=(4.0, 3.0, 5.0);
  - response: out_valid at cycle 21, tnear_out=2.0, tfar_out=3.0, hit=1.
- Ray 2:
  - stimulus: tmin=(1.0, 4.0, 0.5), tmax=(5.0, 3.0, 6.0);
  - response: tnear_out=4.0, tfar_out=3.0, hit=0.
- Ties:
  - stimulus: tmin=(2.0, 2.0, 2.0), tmax=(2.0, 2.0, 2.0);
  - response: hit=1, and tnear/tfar are taken from x, checked by asserting that the registers never update.
- Back-pressure:
  - stimulus: hold out_ready=0 for 10 cycles after out_valid, while pulsing in_valid with a second ray;
  - response: outputs are unchanged and in_ready=0 throughout; the second ray is accepted only after the DONE handshake, and its result is correct.
- Abort:
  - stimulus: assert rst during step2 of a ray, then release and issue Ray 1;
  - response: outputs return to reset values in the same cycle as rst, and the Ray 1 result matches scenario 1 exactly.
- Cross-check:
  - stimulus: repeat scenario 1 at CMP_LAT=1 and CMP_LAT=6;
  - response: out_valid at cycles 11 and 36, with identical results.

Source files
------------

// File: rtl/slab_compare_sched_if.sv
// Handshake, operand and comparator-port bundle for the slab-test sequencer.
// The sequencer connects through the slave modport; the driver side uses master.
interface slab_compare_sched_if #(
  parameter int WIDTH = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   tmin_x, tmin_y, tmin_z;
  logic [WIDTH:0]   tmax_x, tmax_y, tmax_z;
  logic             out_valid;
  logic             out_ready;
  logic             hit;
  logic [WIDTH:0]   tnear_out, tfar_out;
  logic             busy;
  logic [WIDTH:0]   cmp_a, cmp_b;
  logic             cmp_gt;

  modport slave (
    input  in_valid, tmin_x, tmin_y, tmin_z, tmax_x, tmax_y, tmax_z,
    input  out_ready, cmp_gt,
    output in_ready, out_valid, hit, tnear_out, tfar_out, busy, cmp_a, cmp_b
  );

  modport master (
    output in_valid, tmin_x, tmin_y, tmin_z, tmax_x, tmax_y, tmax_z,
    output out_ready, cmp_gt,
    input  in_ready, out_valid, hit, tnear_out, tfar_out, busy, cmp_a, cmp_b
  );
endinterface

// File: rtl/slab_compare_sched.sv
// Ray/AABB slab-test sequencer: reduces tnear=max(tmin), tfar=min(tmax) and
// decides hit through one shared, pipelined FP greater-than comparator.
module slab_compare_sched #(
  parameter int WIDTH   = 14,
  parameter int CMP_LAT = 3
) (
  input logic                clk,
  input logic                rst,
  slab_compare_sched_if.slave bus
);

  localparam int            CW       = $clog2(CMP_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CMP_LAT);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t          state, state_nx;
  logic [WIDTH:0]  tmin_y_q, tmin_z_q, tmax_y_q, tmax_z_q;
  logic [WIDTH:0]  tnear, tfar;
  logic [2:0]      step;
  logic [CW-1:0]   cnt;
  logic            hit_q;
  logic            accept;
  logic            step_end;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign step_end = (state == STEP) && (cnt == CNT_LAST);

  // NOTE: every output and next-state signal gets a default first so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = STEP;
      STEP:    if (step_end && step == 3'd4) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The x-axis distances seed tnear/tfar directly, so only y/z need holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmin_y_q <= '0;
      tmin_z_q <= '0;
      tmax_y_q <= '0;
      tmax_z_q <= '0;
      tnear    <= '0;
      tfar     <= '0;
      step     <= '0;
      cnt      <= '0;
      hit_q    <= 1'b0;
    end else if (accept) begin
      tmin_y_q <= bus.tmin_y;
      tmin_z_q <= bus.tmin_z;
      tmax_y_q <= bus.tmax_y;
      tmax_z_q <= bus.tmax_z;
      tnear    <= bus.tmin_x;
      tfar     <= bus.tmax_x;
      step     <= '0;
      cnt      <= '0;
    end else if (state == STEP) begin
      if (step_end) begin
        cnt  <= '0;
        step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
        // Ties keep the current value, so equal distances resolve to the earlier axis.
        case (step)
          3'd0:    if (bus.cmp_gt) tnear <= tmin_y_q;
          3'd1:    if (bus.cmp_gt) tnear <= tmin_z_q;
          3'd2:    if (bus.cmp_gt) tfar  <= tmax_y_q;
          3'd3:    if (bus.cmp_gt) tfar  <= tmax_z_q;
          3'd4:    hit_q <= ~bus.cmp_gt;
          default: ;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Operands depend only on registered state, so they hold steady for the
  // whole step while the comparator pipeline fills.
  always_comb begin
    bus.cmp_a = '0;
    bus.cmp_b = '0;
    if (state == STEP) begin
      case (step)
        3'd0:    begin bus.cmp_a = tmin_y_q; bus.cmp_b = tnear;    end
        3'd1:    begin bus.cmp_a = tmin_z_q; bus.cmp_b = tnear;    end
        3'd2:    begin bus.cmp_a = tfar;     bus.cmp_b = tmax_y_q; end
        3'd3:    begin bus.cmp_a = tfar;     bus.cmp_b = tmax_z_q; end
        3'd4:    begin bus.cmp_a = tnear;    bus.cmp_b = tfar;     end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.hit       = hit_q;
  assign bus.tnear_out = tnear;
  assign bus.tfar_out  = tfar;

endmodule

// File: tb/tb_slab_compare_sched.sv
// Directed bench for slab_compare_sched: three instances (CMP_LAT 1/3/6) share
// stimulus, each paired with a behavioural pipelined FP greater-than model.
module tb_slab_compare_sched;

  localparam int W = 14;

  // FloPoCo encodings: exn=01 (normal), sign=0, 5-bit exponent (bias 15), 7-bit fraction.
  localparam logic [W:0] F05 = {2'b01, 1'b0, 5'd14, 7'd0};
  localparam logic [W:0] F1  = {2'b01, 1'b0, 5'd15, 7'd0};
  localparam logic [W:0] F2  = {2'b01, 1'b0, 5'd16, 7'd0};
  localparam logic [W:0] F3  = {2'b01, 1'b0, 5'd16, 7'd64};
  localparam logic [W:0] F4  = {2'b01, 1'b0, 5'd17, 7'd0};
  localparam logic [W:0] F5  = {2'b01, 1'b0, 5'd17, 7'd32};
  localparam logic [W:0] F6  = {2'b01, 1'b0, 5'd17, 7'd64};

  typedef struct {
    logic [W:0] tmin_x, tmin_y, tmin_z, tmax_x, tmax_y, tmax_z;
    logic [W:0] tnear, tfar;
    logic       hit;
    logic       hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic [W:0] s_tmin_x, s_tmin_y, s_tmin_z, s_tmax_x, s_tmax_y, s_tmax_z;
  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  slab_compare_sched_if #(.WIDTH(W)) if1 ();
  slab_compare_sched_if #(.WIDTH(W)) if3 ();
  slab_compare_sched_if #(.WIDTH(W)) if6 ();

  assign {if1.in_valid, if1.out_ready, if1.tmin_x, if1.tmin_y, if1.tmin_z, if1.tmax_x, if1.tmax_y, if1.tmax_z}
       = {in_valid, out_ready, s_tmin_x, s_tmin_y, s_tmin_z, s_tmax_x, s_tmax_y, s_tmax_z};
  assign {if3.in_valid, if3.out_ready, if3.tmin_x, if3.tmin_y, if3.tmin_z, if3.tmax_x, if3.tmax_y, if3.tmax_z}
       = {in_valid, out_ready, s_tmin_x, s_tmin_y, s_tmin_z, s_tmax_x, s_tmax_y, s_tmax_z};
  assign {if6.in_valid, if6.out_ready, if6.tmin_x, if6.tmin_y, if6.tmin_z, if6.tmax_x, if6.tmax_y, if6.tmax_z}
       = {in_valid, out_ready, s_tmin_x, s_tmin_y, s_tmin_z, s_tmax_x, s_tmax_y, s_tmax_z};

  slab_compare_sched #(.WIDTH(W), .CMP_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  slab_compare_sched #(.WIDTH(W), .CMP_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  slab_compare_sched #(.WIDTH(W), .CMP_LAT(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  // gt = 1 iff a-b is a normal positive number; non-normal operands give 0.
  function automatic logic fp_gt(input logic [W:0] a, input logic [W:0] b);
    if (a[W:W-1] != 2'b01 || b[W:W-1] != 2'b01) return 1'b0;
    if (a[W-2] != b[W-2]) return b[W-2];
    if (a[W-2] == 1'b0) return a[W-3:0] > b[W-3:0];
    return a[W-3:0] < b[W-3:0];
  endfunction

  logic       p1;
  logic [2:0] p3;
  logic [5:0] p6;
  always @(posedge clk) begin
    p1 <= fp_gt(if1.cmp_a, if1.cmp_b);
    p3 <= {p3[1:0], fp_gt(if3.cmp_a, if3.cmp_b)};
    p6 <= {p6[4:0], fp_gt(if6.cmp_a, if6.cmp_b)};
  end
  assign if1.cmp_gt = p1;
  assign if3.cmp_gt = p3[2];
  assign if6.cmp_gt = p6[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    s_tmin_x = v.tmin_x; s_tmin_y = v.tmin_y; s_tmin_z = v.tmin_z;
    s_tmax_x = v.tmax_x; s_tmax_y = v.tmax_y; s_tmax_z = v.tmax_z;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  32'(if3.in_ready),  32'd1);
    check({tag, " out_valid"}, 32'(if3.out_valid), 32'd0);
    check({tag, " busy"},      32'(if3.busy),      32'd0);
    check({tag, " hit"},       32'(if3.hit),       32'd0);
    check({tag, " tnear"},     32'(if3.tnear_out), 32'd0);
    check({tag, " tfar"},      32'(if3.tfar_out),  32'd0);
    check({tag, " cmp_a"},     32'(if3.cmp_a),     32'd0);
    check({tag, " cmp_b"},     32'(if3.cmp_b),     32'd0);
  endtask

  // Counts cycles after the accept edge until out_valid; returns at that negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if3.out_valid && lat < 100);
  endtask

  task automatic run_ray(input vec_t v, input string tag);
    int k = 0;
    int lat = 0;
    while (!if3.in_ready && k < 100) begin @(negedge clk); k++; end
    check({tag, " idle"}, 32'(if3.in_ready), 32'd1);
    apply(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (v.hold && !if3.out_valid) begin
        check({tag, " tnear hold"}, 32'(if3.tnear_out), 32'(v.tmin_x));
        check({tag, " tfar hold"},  32'(if3.tfar_out),  32'(v.tmax_x));
      end
    end while (!if3.out_valid && lat < 100);
    check({tag, " latency"}, 32'(lat),           32'd21);
    check({tag, " tnear"},   32'(if3.tnear_out), 32'(v.tnear));
    check({tag, " tfar"},    32'(if3.tfar_out),  32'(v.tfar));
    check({tag, " hit"},     32'(if3.hit),       32'(v.hit));
    @(negedge clk);
    check({tag, " next in_ready"},  32'(if3.in_ready),  32'd1);
    check({tag, " next out_valid"}, 32'(if3.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int got_lat[3];
    logic [W:0] got_tn[3], got_tf[3];
    logic got_hit[3];

    vecs[0] = '{F1,  F2,  F05, F4,  F3, F5, F2, F3,  1'b1, 1'b0};
    vecs[1] = '{F1,  F4,  F05, F5,  F3, F6, F4, F3,  1'b0, 1'b0};
    vecs[2] = '{F2,  F2,  F2,  F2,  F2, F2, F2, F2,  1'b1, 1'b1};
    vecs[3] = '{F3,  F1,  F1,  F6,  F5, F4, F3, F4,  1'b1, 1'b0};
    vecs[4] = '{F05, F05, F1,  F05, F1, F2, F1, F05, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_ray(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: result frozen, second ray ignored until the DONE handshake.
    out_ready = 1'b0;
    apply(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("bp latency", 32'(lat), 32'd21);
    apply(vecs[1]);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      @(negedge clk);
      check("bp out_valid", 32'(if3.out_valid), 32'd1);
      check("bp in_ready",  32'(if3.in_ready),  32'd0);
      check("bp tnear",     32'(if3.tnear_out), 32'(F2));
      check("bp tfar",      32'(if3.tfar_out),  32'(F3));
      check("bp hit",       32'(if3.hit),       32'd1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp handshake in_ready",  32'(if3.in_ready),  32'd1);
    check("bp handshake out_valid", 32'(if3.out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("bp ray2 latency", 32'(lat),           32'd21);
    check("bp ray2 tnear",   32'(if3.tnear_out), 32'(F4));
    check("bp ray2 tfar",    32'(if3.tfar_out),  32'(F3));
    check("bp ray2 hit",     32'(if3.hit),       32'd0);
    @(negedge clk);

    // Abort during step2 of a ray, leaving hit=1 from the previous result.
    run_ray(vecs[0], "pre-abort");
    apply(vecs[1]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort step2 busy",  32'(if3.busy),  32'd1);
    check("abort step2 cmp_a", 32'(if3.cmp_a), 32'(F5));
    check("abort step2 cmp_b", 32'(if3.cmp_b), 32'(F3));
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_ray(vecs[0], "post-abort");

    // Cross-check: the same ray on all three comparator latencies at once.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_lat = '{0, 0, 0};
    got_tn  = '{'0, '0, '0};
    got_tf  = '{'0, '0, '0};
    got_hit = '{1'b0, 1'b0, 1'b0};
    apply(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (if1.out_valid && got_lat[0] == 0) begin
        got_lat[0] = n; got_tn[0] = if1.tnear_out; got_tf[0] = if1.tfar_out; got_hit[0] = if1.hit;
      end
      if (if3.out_valid && got_lat[1] == 0) begin
        got_lat[1] = n; got_tn[1] = if3.tnear_out; got_tf[1] = if3.tfar_out; got_hit[1] = if3.hit;
      end
      if (if6.out_valid && got_lat[2] == 0) begin
        got_lat[2] = n; got_tn[2] = if6.tnear_out; got_tf[2] = if6.tfar_out; got_hit[2] = if6.hit;
      end
    end
    check("lat1 latency", 32'(got_lat[0]), 32'd11);
    check("lat3 latency", 32'(got_lat[1]), 32'd21);
    check("lat6 latency", 32'(got_lat[2]), 32'd36);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("xchk%0d tnear", j), 32'(got_tn[j]),  32'(F2));
      check($sformatf("xchk%0d tfar", j),  32'(got_tf[j]),  32'(F3));
      check($sformatf("xchk%0d hit", j),   32'(got_hit[j]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
